seq_squarer: RTL and testbench
==============================

Name: seq_squarer

Overview:
Parametrised, multi-cycle unsigned squarer. It is the sequential successor to the team's combinational 3-bit squarer and generalises the operand width to WIDTH. It computes in*in with an iterative shift-add datapath, one partial product per clock, behind a start/busy/done handshake. It is intended for datapaths where a WIDTH x WIDTH array multiplier is too large, and it replaces the combinational squarer wherever WIDTH > 3.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..16; result width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request; sampled on the clock edge; accepted only in IDLE or DONE.
in  input  WIDTH  unsigned operand; sampled in the cycle start is accepted.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse when out becomes valid.
out  output  2*WIDTH  in*in; holds its value until the next result is written.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst); all state updates on rising clk only.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, out=0, internal operand/accumulator/counter=0. rst has priority over start.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - DONE: single cycle.
- IDLE: start=1 -> latch in into operand register A and multiplicand register M (zero-extended to 2*WIDTH), clear accumulator, set counter=0, go to CALC.
- CALC, each cycle:
  - if A[0]=1, acc <= acc + M;
  - then A <= A>>1, M <= M<<1, counter <= counter+1.
  - Once WIDTH iterations have executed (counter reaches WIDTH-1 and that iteration completes), go to DONE and write out <= final acc.
- Width rules: acc and M are 2*WIDTH bits; no overflow is possible, since the maximum result (2^WIDTH-1)^2 < 2^(2*WIDTH). All arithmetic is unsigned.
- DONE: done=1, busy=0 for exactly one cycle, out valid. Next state is IDLE. If start=1 in the DONE cycle, the new operand is accepted as from IDLE (back-to-back operation) and the next state is CALC.
- Latency: start accepted at edge N; busy=1 during cycles N+1..N+WIDTH; done=1 and new out visible in cycle N+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. in changes during CALC have no effect.
- out changes only on reset or on entry to DONE. It holds the last result through IDLE and the next CALC.
- in=0 still takes the full WIDTH cycles, giving out=0 (no early termination, so latency is fixed).
- Reset asserted mid-CALC aborts the operation: no done pulse, out=0, and the block is ready for start on the first cycle after rst deasserts.
- done and busy are never high simultaneously.

Test Plan:
- WIDTH=3 exhaustive: apply in=0..7 sequentially with start, wait for done each time -> out = 0,1,4,9,16,25,36,49 (49 = 6'b110001); done exactly 4 cycles after each accepted start.
- WIDTH=8 corners: in=0 -> out=0; in=255 -> out=65025 (16'hFE01); in=13 -> out=169; done pulse at cycle N+9, one cycle wide; busy high for cycles N+1..N+8.
- Ignore while busy: start in=10, then pulse start with in=3 on cycle N+4 -> single done at N+9 with out=100; no second done follows.
- Back-to-back: start in=200; hold start=1 with in=7 during the DONE cycle -> first done shows out=40000; second done 9 cycles later shows out=49; out holds 40000 in between.
- Reset mid-op: start in=255, assert rst at cycle N+3 for 1 cycle -> busy=0, done=0, out=0 from the next cycle; no done pulse appears; a subsequent start in=2 yields out=4.
- Hold check: after a result of 169, idle 20 cycles with in toggling randomly -> out stays 169, done stays 0.

Source files
------------

// File: rtl/seq_squarer.sv
// seq_squarer: multi-cycle unsigned squarer using an iterative shift-add datapath.
// One partial product is added per clock; start/busy/done handshake around it.
module seq_squarer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] m;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               last;

    // Datapath helpers: conditional partial-product add, accept and last-iteration flags.
    always_comb begin
        acc_sum = a[0] ? (acc + m) : acc;
        accept  = start && ((state == IDLE) || (state == DONE));
        last    = (cnt == LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand, accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            m   <= '0;
            acc <= '0;
            cnt <= '0;
            out <= '0;
        end else if (accept) begin
            a   <= in;
            m   <= {{WIDTH{1'b0}}, in};
            acc <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            acc <= acc_sum;
            a   <= a >> 1;
            m   <= m << 1;
            cnt <= cnt + 1'b1;
            if (last) out <= acc_sum;
        end
    end

    // Status outputs decoded from state; CALC and DONE are exclusive.
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_seq_squarer.sv
// tb_seq_squarer: directed self-checking bench for seq_squarer at WIDTH=3 and WIDTH=8.
module tb_seq_squarer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start3 = 1'b0;
    logic [2:0]  in3 = '0;
    logic        busy3;
    logic        done3;
    logic [5:0]  out3;
    logic        start8 = 1'b0;
    logic [7:0]  in8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] out8;

    int checks = 0;
    int errors = 0;
    int last3  = 0;
    int last8  = 0;

    seq_squarer #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in(in3),
        .busy(busy3), .done(done3), .out(out3)
    );

    seq_squarer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in(in8),
        .busy(busy8), .done(done8), .out(out8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check the full busy/done/out timeline.
    task automatic run(input bit w8, input int v, input int exp);
        int lat;
        lat = w8 ? 8 : 3;
        if (w8) begin start8 = 1'b1; in8 = 8'(v); end
        else    begin start3 = 1'b1; in3 = 3'(v); end
        step();
        if (w8) begin start8 = 1'b0; in8 = ~in8; end
        else    begin start3 = 1'b0; in3 = ~in3; end
        for (int i = 1; i <= lat; i++) begin
            check("busy_calc", w8 ? int'(busy8) : int'(busy3), 1);
            check("done_calc", w8 ? int'(done8) : int'(done3), 0);
            check("out_hold",  w8 ? int'(out8)  : int'(out3), w8 ? last8 : last3);
            step();
        end
        check("done_pulse", w8 ? int'(done8) : int'(done3), 1);
        check("busy_done",  w8 ? int'(busy8) : int'(busy3), 0);
        check("result",     w8 ? int'(out8)  : int'(out3), exp);
        step();
        check("done_width", w8 ? int'(done8) : int'(done3), 0);
        if (w8) last8 = exp; else last3 = exp;
    endtask

    int sq3 [8] = '{0, 1, 4, 9, 16, 25, 36, 49};

    initial begin
        step();
        step();
        check("rst_busy8", int'(busy8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_out8",  int'(out8), 0);
        check("rst_out3",  int'(out3), 0);
        rst = 1'b0;
        step();

        // WIDTH=3 exhaustive
        for (int v = 0; v < 8; v++) run(1'b0, v, sq3[v]);

        // WIDTH=8 corners
        run(1'b1, 0, 0);
        run(1'b1, 255, 65025);
        run(1'b1, 13, 169);

        // Hold: idle with toggling operand
        for (int i = 0; i < 20; i++) begin
            in8 = 8'($urandom_range(0, 255));
            step();
            check("idle_out", int'(out8), 169);
            check("idle_done", int'(done8), 0);
        end

        // Start while busy is ignored
        start8 = 1'b1; in8 = 8'd10;
        step();
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin start8 = 1'b1; in8 = 8'd3; end
            else        start8 = 1'b0;
            check("ign_busy", int'(busy8), 1);
            check("ign_done", int'(done8), 0);
            step();
        end
        start8 = 1'b0;
        check("ign_done_pulse", int'(done8), 1);
        check("ign_result", int'(out8), 100);
        for (int i = 0; i < 12; i++) begin
            step();
            check("ign_no_second", int'(done8), 0);
            check("ign_out_hold", int'(out8), 100);
        end

        // Back-to-back: start held in the DONE cycle
        last8 = 100;
        start8 = 1'b1; in8 = 8'd200;
        step();
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        check("b2b_done1", int'(done8), 1);
        check("b2b_res1", int'(out8), 40000);
        start8 = 1'b1; in8 = 8'd7;
        step();
        start8 = 1'b0; in8 = 8'd99;
        for (int i = 1; i <= 8; i++) begin
            check("b2b_busy", int'(busy8), 1);
            check("b2b_out_hold", int'(out8), 40000);
            step();
        end
        check("b2b_done2", int'(done8), 1);
        check("b2b_res2", int'(out8), 49);
        step();
        last8 = 49;

        // Reset mid-operation
        start8 = 1'b1; in8 = 8'd255;
        step();
        start8 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_busy", int'(busy8), 0);
        check("mrst_done", int'(done8), 0);
        check("mrst_out", int'(out8), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mrst_no_done", int'(done8), 0);
        end
        last8 = 0;
        run(1'b1, 2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
